seq_detect_param: RTL

Parametrised serial pattern detector, the successor to the fixed 5-state Moore sequence detectors in the lab datapath.
- Pattern width is set at elaboration; the pattern value and overlap mode are loaded at run time.
- Adds input qualification (din_vld), enable control and a saturating match counter.
- Sits on a 1-bit serial stream and drives a registered one-cycle match strobe to downstream counters and LEDs.

---
 rtl/seq_detect_param.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/seq_detect_param.sv
// -----------------------------------------------------------------------------
// seq_detect_param
//
// Parametrised serial pattern detector. A 1-bit stream (din, qualified by
// din_vld) is shifted into a history window and compared against a pattern
// loaded at run time. A registered one-cycle strobe (dout) marks every match
// and a saturating counter (match_cnt) tallies matches since the last load.
//
// Parameters:
//   PAT_W  pattern length in bits (2..16)
//   CNT_W  width of the saturating match counter
//
// Ports:
//   clk          system clock, rising edge
//   clr_n        asynchronous active-low reset
//   en           detector enable; 0 returns the detector to IDLE
//   cfg_load     latch cfg_pat/cfg_overlap (and cfg_mask) and clear
//                match_cnt; only honoured while en=0
//   cfg_pat      pattern; bit PAT_W-1 is the first bit on the stream
//   cfg_overlap  1 = overlapping matches, 0 = restart after each match
//   cfg_mask     (SEQ_MASK_EN only) per-position don't-care mask
//   din_vld      din is sampled on this edge
//   din          serial data bit
//   dout         registered match strobe
//   match_cnt    saturating number of matches since the last cfg_load
//   state        00 IDLE, 01 FILL, 10 RUN
//
// Build option:
//   SEQ_MASK_EN  when defined, adds cfg_mask; masked positions are ignored in
//                the compare. When undefined the compare is exact.
// -----------------------------------------------------------------------------
module seq_detect_param #(
    parameter int PAT_W = 5,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             en,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pat,
    input  logic             cfg_overlap,
`ifdef SEQ_MASK_EN
    input  logic [PAT_W-1:0] cfg_mask,
`endif
    input  logic             din_vld,
    input  logic             din,
    output logic             dout,
    output logic [CNT_W-1:0] match_cnt,
    output logic [1:0]       state
);

    localparam int FILL_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    // fill never needs to hold PAT_W itself: the bit that would take it
    // there moves the FSM to RUN instead.
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_FILL = 2'b01,
        ST_RUN  = 2'b10
    } state_t;

    state_t             state_q,   state_d;
    logic [PAT_W-1:0]   pat_q,     pat_d;
    logic               overlap_q, overlap_d;
    logic [PAT_W-1:0]   hist_q,    hist_d;
    logic [FILL_W-1:0]  fill_q,    fill_d;
    logic               dout_q,    dout_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [PAT_W-1:0]   mask_q;
`ifdef SEQ_MASK_EN
    logic [PAT_W-1:0]   mask_d;
`else
    assign mask_q = '0;
`endif

    logic [PAT_W-1:0]   hist_next;
    logic               cfg_take;
    logic               cmp_window;
    logic               match;
    // The oldest history bit is shifted out before it is ever compared.
    logic               hist_msb_unused;

    assign hist_msb_unused = hist_q[PAT_W-1];
    assign hist_next  = {hist_q[PAT_W-2:0], din};
    assign cfg_take   = cfg_load & ~en;
    // The compare is live in RUN, and in FILL only for the bit that completes
    // the first full window.
    assign cmp_window = (state_q == ST_RUN) ||
                        ((state_q == ST_FILL) && (fill_q == FILL_LAST));
    // en=0 wins over a same-cycle data bit.
    assign match      = en && din_vld && cmp_window &&
                        (((hist_next ^ pat_q) & ~mask_q) == '0);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= ST_IDLE;
            pat_q     <= '0;
            overlap_q <= 1'b0;
            hist_q    <= '0;
            fill_q    <= '0;
            dout_q    <= 1'b0;
            cnt_q     <= '0;
`ifdef SEQ_MASK_EN
            mask_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            overlap_q <= overlap_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            dout_q    <= dout_d;
            cnt_q     <= cnt_d;
`ifdef SEQ_MASK_EN
            mask_q    <= mask_d;
`endif
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        overlap_d = overlap_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        dout_d    = 1'b0;
        cnt_d     = cnt_q;
`ifdef SEQ_MASK_EN
        mask_d    = mask_q;
`endif

        if (cfg_take) begin
            pat_d     = cfg_pat;
            overlap_d = cfg_overlap;
            cnt_d     = '0;
`ifdef SEQ_MASK_EN
            mask_d    = cfg_mask;
`endif
        end else if (match && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_FILL;
                    hist_d  = '0;
                    fill_d  = '0;
                end
            end
            ST_FILL, ST_RUN: begin
                if (!en) begin
                    state_d = ST_IDLE;
                    hist_d  = '0;
                    fill_d  = '0;
                end else if (din_vld) begin
                    hist_d = hist_next;
                    if (match) begin
                        dout_d = 1'b1;
                        if (!overlap_q) begin
                            // Non-overlapping: matched bits are not reused.
                            state_d = ST_FILL;
                            fill_d  = '0;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else if (state_q == ST_FILL) begin
                        if (fill_q == FILL_LAST) begin
                            state_d = ST_RUN;
                        end else begin
                            fill_d = fill_q + FILL_W'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                hist_d  = '0;
                fill_d  = '0;
            end
        endcase
    end

    // --------------------------------------------------------------- outputs
    always_comb begin
        dout      = dout_q;
        match_cnt = cnt_q;
        state     = state_q;
    end

endmodule
